// File: rtl/add12u_rr_share.sv
// ============================================================================
// add12u_rr_share
// ----------------------------------------------------------------------------
// Round-robin scheduler that time-shares one approximate 12-bit unsigned adder
// among NREQ requesters. Each cycle at most one operand pair is issued to the
// adder. The 13-bit sum and the winning requester index are captured in an
// output register that supports valid/ready backpressure.
//
// Build option:
//   ADD12U_EXACT_EN  when defined, the approximate adder is replaced by an
//                    exact 13-bit sum A+B. Handshake, latency and arbitration
//                    are identical in both builds.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   IDW   width of rsp_id, 2**IDW >= NREQ
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand valid
//   req_a      operand A, requester i at bits [12*i+11:12*i]
//   req_b      operand B, same packing as req_a
//   req_ready  per-requester accept, one-hot or zero
//   rsp_valid  result register holds a result
//   rsp_ready  consumer accepts the result
//   rsp_sum    13-bit (approximate) sum
//   rsp_id     index of the requester that produced rsp_sum
//   busy       result pending or any requester valid
// ============================================================================
module add12u_rr_share #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*12-1:0]   req_a,
    input  logic [NREQ*12-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [12:0]          rsp_sum,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic           any_valid;
    logic           can_load;
    logic           accept;
    logic [11:0]    a_sel;
    logic [11:0]    b_sel;
    logic [12:0]    add_sum;

    // Offset from the round-robin pointer, wrapped into 0..NREQ-1. NREQ need
    // not be a power of two, so the wrap is done explicitly.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // Priority search starting at ptr. Walking the offsets from the far end
    // down to zero lets the closest valid requester overwrite any earlier hit,
    // so the last assignment is the winner.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(ptr, k)]) begin
                winner    = wrap_idx(ptr, k);
                any_valid = 1'b1;
            end
        end
    end

    // The output slot can take new data when it is empty or being drained in
    // the same cycle; that keeps a full pipeline at one result per cycle.
    // rst_n is folded in so nothing is granted while reset is held.
    assign can_load = ~rsp_valid | rsp_ready;
    assign accept   = rst_n & can_load & any_valid;

    // Only the winner sees ready, and only when the slot can take its result.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign a_sel = req_a[winner*12 +: 12];
    assign b_sel = req_b[winner*12 +: 12];

`ifdef ADD12U_EXACT_EN
    // Golden reference build: plain 13-bit sum.
    assign add_sum = {1'b0, a_sel} + {1'b0, b_sel};
`else
    logic approx_carry;
    logic unused_approx_bits;

    // Approximate adder. Bits 0..6 are wired straight from selected operand
    // bits, bit 7 is a full adder whose third input is B6 instead of a real
    // carry, and bits 8..11 form an exact ripple chain seeded from bit 7.
    always_comb begin
        add_sum      = '0;
        approx_carry = 1'b0;
        add_sum[0]   = a_sel[0];
        add_sum[1]   = b_sel[2];
        add_sum[2]   = b_sel[4];
        add_sum[3]   = b_sel[3];
        add_sum[4]   = a_sel[4];
        add_sum[5]   = a_sel[5];
        add_sum[6]   = a_sel[6];
        add_sum[7]   = a_sel[7] ^ b_sel[7] ^ b_sel[6];
        approx_carry = (a_sel[7] & b_sel[7]) | (a_sel[7] & b_sel[6])
                     | (b_sel[7] & b_sel[6]);
        for (int i = 8; i < 12; i++) begin
            add_sum[i]   = a_sel[i] ^ b_sel[i] ^ approx_carry;
            approx_carry = (a_sel[i] & b_sel[i]) | (a_sel[i] & approx_carry)
                         | (b_sel[i] & approx_carry);
        end
        add_sum[12] = approx_carry;
    end

    // Operand bits the approximate function ignores.
    assign unused_approx_bits = ^{a_sel[3:1], b_sel[5], b_sel[1:0]};
`endif

    // Result register and round-robin pointer. An accept loads new data and
    // moves the pointer past the winner; a drain without accept empties the
    // slot; a stall leaves everything untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= add_sum;
            rsp_id    <= winner;
            ptr       <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign busy = rsp_valid | (|req_valid);

endmodule
